// File: rtl/fsm_linha_pkg.sv
// Shared constants for the bottling line sequencer: state encoding,
// watchdog default and display counter limits.
package fsm_linha_pkg;

   localparam logic [2:0] IDLE        = 3'd0;
   localparam logic [2:0] MOVENDO     = 3'd1;
   localparam logic [2:0] ENCHENDO    = 3'd2;
   localparam logic [2:0] VEDANDO     = 3'd3;
   localparam logic [2:0] VERIFICANDO = 3'd4;
   localparam logic [2:0] DESCARTE    = 3'd5;
   localparam logic [2:0] ERRO        = 3'd6;

   localparam logic [25:0] TIMEOUT_PADRAO = 26'd50000000;

   localparam logic [3:0] MAX_GARRAFAS = 4'd11;
   localparam logic [6:0] MAX_DUZIAS   = 7'd99;

endpackage

// File: rtl/contador_duzias.sv
// Approved-bottle counter: mod-12 units with carry into a dozens counter
// that saturates at 99 while the units keep wrapping.
module contador_duzias
   import fsm_linha_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   output logic [3:0] garrafas,
   output logic [6:0] duzias
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         garrafas <= 4'd0;
         duzias   <= 7'd0;
      end else if (inc) begin
         if (garrafas == MAX_GARRAFAS) begin
            garrafas <= 4'd0;
            if (duzias != MAX_DUZIAS) begin
               duzias <= duzias + 7'd1;
            end
         end else begin
            garrafas <= garrafas + 4'd1;
         end
      end
   end

endmodule

// File: rtl/fsm_mestre_esteira.sv
// Master conveyor sequencer: moves bottles to the station, drives the fill,
// capping and CQ slaves via cmd/done handshakes, counts approvals, watchdogs slaves.
module fsm_mestre_esteira
   import fsm_linha_pkg::*;
#(
   parameter logic [25:0] TIMEOUT = TIMEOUT_PADRAO
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       sensor_posicao,
   input  logic       enchimento_concluido,
   input  logic       vedacao_concluida,
   input  logic       cq_concluida,
   input  logic       garrafa_aprovada,
   input  logic       descarte_ativo,
   output logic       motor_ativo,
   output logic       cmd_encher,
   output logic       cmd_vedar,
   output logic       cmd_verificar,
   output logic       alarme,
   output logic [3:0] contador_garrafas,
   output logic [6:0] contador_duzias,
   output logic [2:0] estado
);

   logic [2:0]  estado_q, estado_d;
   logic        parada_q, parada_d;
   logic        sensor_ant_q;
   logic [25:0] wd_q, wd_d;
   logic        inc;
   logic        sensor_subida;
   logic        monitorado;
   logic        estouro;

   assign sensor_subida = sensor_posicao & ~sensor_ant_q;
   assign monitorado    = (estado_q == ENCHENDO) || (estado_q == VEDANDO) ||
                          (estado_q == VERIFICANDO) || (estado_q == DESCARTE);
   assign estouro       = monitorado && (wd_q == TIMEOUT - 26'd1);

   // Watchdog is checked first in every slave phase so it beats a same-cycle done.
   always_comb begin
      estado_d = estado_q;
      parada_d = parada_q;
      inc      = 1'b0;
      case (estado_q)
         IDLE: begin
            if (start && !stop) estado_d = MOVENDO;
         end
         MOVENDO: begin
            if (stop || parada_q)   estado_d = IDLE;
            else if (sensor_subida) estado_d = ENCHENDO;
         end
         ENCHENDO: begin
            if (estouro)                   estado_d = ERRO;
            else if (enchimento_concluido) estado_d = VEDANDO;
         end
         VEDANDO: begin
            if (estouro)                estado_d = ERRO;
            else if (vedacao_concluida) estado_d = VERIFICANDO;
         end
         VERIFICANDO: begin
            if (estouro) begin
               estado_d = ERRO;
            end else if (cq_concluida && garrafa_aprovada) begin
               estado_d = MOVENDO;
               inc      = 1'b1;
            end else if (descarte_ativo) begin
               estado_d = DESCARTE;
            end
         end
         DESCARTE: begin
            if (estouro)             estado_d = ERRO;
            else if (!descarte_ativo) estado_d = MOVENDO;
         end
         ERRO: begin
            if (stop) estado_d = IDLE;
         end
         default: estado_d = IDLE;
      endcase

      if (stop && monitorado) parada_d = 1'b1;
      // Any return to IDLE consumes a pending stop request.
      if (estado_d == IDLE) parada_d = 1'b0;
   end

   always_comb begin
      if ((estado_d != estado_q) || !monitorado) wd_d = 26'd0;
      else                                       wd_d = wd_q + 26'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q     <= IDLE;
         parada_q     <= 1'b0;
         sensor_ant_q <= 1'b0;
         wd_q         <= 26'd0;
      end else begin
         estado_q     <= estado_d;
         parada_q     <= parada_d;
         sensor_ant_q <= sensor_posicao;
         wd_q         <= wd_d;
      end
   end

   always_comb begin
      motor_ativo   = (estado_q == MOVENDO);
      cmd_encher    = (estado_q == ENCHENDO);
      cmd_vedar     = (estado_q == VEDANDO);
      cmd_verificar = (estado_q == VERIFICANDO);
      alarme        = (estado_q == ERRO);
      estado        = estado_q;
   end

   contador_duzias u_contador (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc),
      .garrafas (contador_garrafas),
      .duzias   (contador_duzias)
   );

endmodule
